// File: rtl/pipelined_reduce_gate.sv
// pipelined_reduce_gate
//   Multi-lane, mode-selectable bitwise reduction gate (a generalised NOR).
//   Each of CHANNELS lanes reduces a WIDTH-bit slice of in_data to one bit
//   using the function picked by mode. A two-stage valid/ready pipeline
//   (S1 operand register, S2 result register) gives one beat per cycle.
//   The block also counts non-zero result beats and flags reserved modes.
//
// Ports
//   clk        rising-edge clock
//   aresetn    asynchronous active-low reset
//   in_valid   input beat valid
//   in_ready   pipeline can accept a beat this cycle (combinational)
//   in_data    lane operands, lane ch at [ch*WIDTH +: WIDTH]
//   mode       0 NOR, 1 OR, 2 AND, 3 NAND, 4 XOR, 5 XNOR, 6-7 reserved
//   out_valid  result beat valid
//   out_ready  downstream accepts result
//   out_data   per-lane reduction result
//   cnt_clr    synchronous clear of hit_cnt and mode_err
//   hit_cnt    saturating count of handshaken results with out_data != 0
//   mode_err   sticky flag: a reserved mode reached S2
module pipelined_reduce_gate #(
  parameter int unsigned WIDTH    = 2,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      aresetn,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [2:0]                mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS-1:0]       out_data,
  input  logic                      cnt_clr,
  output logic [CNT_W-1:0]          hit_cnt,
  output logic                      mode_err
);

  localparam int unsigned DATA_W = CHANNELS * WIDTH;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [2:0] MODE_NOR  = 3'd0;
  localparam logic [2:0] MODE_OR   = 3'd1;
  localparam logic [2:0] MODE_AND  = 3'd2;
  localparam logic [2:0] MODE_NAND = 3'd3;
  localparam logic [2:0] MODE_XOR  = 3'd4;
  localparam logic [2:0] MODE_XNOR = 3'd5;

  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic [2:0]        s1_mode;

  logic                s2_free_c;
  logic                xfer_c;
  logic                accept_c;
  logic                consume_c;
  logic                mode_rsvd_c;
  logic [CHANNELS-1:0] reduced_c;
  logic [WIDTH-1:0]    lane_c;

  // Handshake and advance qualifiers
  assign s2_free_c   = !out_valid || out_ready;
  assign xfer_c      = s1_valid && s2_free_c;
  assign in_ready    = aresetn && (!s1_valid || s2_free_c);
  assign accept_c    = in_valid && in_ready;
  assign consume_c   = out_valid && out_ready;
  assign mode_rsvd_c = s1_mode[2] && s1_mode[1];

  // Per-lane reduction of the S1 operands
  always_comb begin
    reduced_c = '0;
    lane_c    = '0;
    for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
      lane_c = s1_data[ch*WIDTH +: WIDTH];
      unique case (s1_mode)
        MODE_NOR:  reduced_c[ch] = ~|lane_c;
        MODE_OR:   reduced_c[ch] =  |lane_c;
        MODE_AND:  reduced_c[ch] =  &lane_c;
        MODE_NAND: reduced_c[ch] = ~&lane_c;
        MODE_XOR:  reduced_c[ch] =  ^lane_c;
        MODE_XNOR: reduced_c[ch] = ~^lane_c;
        default:   reduced_c[ch] = 1'b0;
      endcase
    end
  end

  // Stage 1: operand capture; a same-cycle accept refills a departing slot
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= '0;
    end else begin
      if (accept_c) begin
        s1_valid <= 1'b1;
        s1_data  <= in_data;
        s1_mode  <= mode;
      end else if (xfer_c) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2: result register, held while stalled
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (xfer_c) begin
        out_valid <= 1'b1;
        out_data  <= reduced_c;
      end else if (consume_c) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Hit counter and sticky reserved-mode flag; clear has priority
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      hit_cnt  <= '0;
      mode_err <= 1'b0;
    end else if (cnt_clr) begin
      hit_cnt  <= '0;
      mode_err <= 1'b0;
    end else begin
      if (consume_c && (|out_data) && (hit_cnt != CNT_MAX)) begin
        hit_cnt <= hit_cnt + CNT_W'(1);
      end
      if (xfer_c && mode_rsvd_c) begin
        mode_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_reduce_gate.sv
// tb_pipelined_reduce_gate
//   Directed bench for pipelined_reduce_gate. A default instance (CNT_W=8)
//   and a CNT_W=2 instance share all inputs; the second exposes counter
//   saturation. Inputs are driven on the falling edge, outputs sampled there.
module tb_pipelined_reduce_gate;

  logic       clk;
  logic       aresetn;
  logic       in_valid;
  logic [7:0] in_data;
  logic [2:0] mode;
  logic       out_ready;
  logic       cnt_clr;

  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic [7:0] hit_cnt;
  logic       mode_err;

  logic       in_ready2;
  logic       out_valid2;
  logic [3:0] out_data2;
  logic [1:0] hit_cnt2;
  logic       mode_err2;

  int tests;
  int fails;

  pipelined_reduce_gate #(.WIDTH(2), .CHANNELS(4), .CNT_W(8)) dut (
    .clk(clk), .aresetn(aresetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .cnt_clr(cnt_clr), .hit_cnt(hit_cnt), .mode_err(mode_err)
  );

  pipelined_reduce_gate #(.WIDTH(2), .CHANNELS(4), .CNT_W(2)) dut_sat (
    .clk(clk), .aresetn(aresetn), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .mode(mode), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .cnt_clr(cnt_clr), .hit_cnt(hit_cnt2), .mode_err(mode_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    aresetn = 1'b0; in_valid = 1'b0; in_data = '0; mode = '0;
    out_ready = 1'b0; cnt_clr = 1'b0;
    @(negedge clk); #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    tests++; if (out_data !== 4'd0) begin fails++; $display("FAIL rst_out_data got %b exp 0000", out_data); end
    tests++; if (hit_cnt !== 8'd0) begin fails++; $display("FAIL rst_hit_cnt got %0d exp 0", hit_cnt); end
    tests++; if (mode_err !== 1'b0) begin fails++; $display("FAIL rst_mode_err got %b exp 0", mode_err); end
    @(negedge clk);
    aresetn = 1'b1; #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_release_in_ready got %b exp 1", in_ready); end
  endtask

  // NOR on lane0 = 00,01,10,11; idle lanes are 00 so their NOR is 1
  task automatic test_nor_lane0();
    logic [3:0] exp_o [4];
    exp_o = '{4'b1111, 4'b1110, 4'b1110, 4'b1110};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'(i); mode = 3'd0; #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL t1_in_ready i=%0d got %b exp 1", i, in_ready); end
      @(negedge clk);
      in_valid = 1'b0; #1;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL t1_early_valid i=%0d got %b exp 0", i, out_valid); end
      @(negedge clk); #1;
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL t1_out_valid i=%0d got %b exp 1", i, out_valid); end
      tests++; if (out_data !== exp_o[i]) begin fails++; $display("FAIL t1_out_data i=%0d got %b exp %b", i, out_data, exp_o[i]); end
    end
    @(negedge clk); #1;
    tests++; if (hit_cnt !== 8'd4) begin fails++; $display("FAIL t1_hit_cnt got %0d exp 4", hit_cnt); end
  endtask

  // All six modes on lanes 11,10,01,00, streamed back to back
  task automatic test_modes();
    logic [3:0] exp_o [6];
    exp_o = '{4'b0001, 4'b1110, 4'b1000, 4'b0111, 4'b0110, 4'b1001};
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k < 6) begin
        in_valid = 1'b1; in_data = 8'b11_10_01_00; mode = 3'(k);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (k < 6) begin
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL t2_in_ready k=%0d got %b exp 1", k, in_ready); end
      end
      if (k >= 2) begin
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL t2_out_valid k=%0d got %b exp 1", k, out_valid); end
        tests++; if (out_data !== exp_o[k-2]) begin fails++; $display("FAIL t2_out_data mode=%0d got %b exp %b", k-2, out_data, exp_o[k-2]); end
      end
    end
    @(negedge clk); #1;
    tests++; if (hit_cnt !== 8'd10) begin fails++; $display("FAIL t2_hit_cnt got %0d exp 10", hit_cnt); end
  endtask

  // 10 OR beats whose results are 1..10; out_ready low in cycles 3-6
  task automatic test_back_to_back();
    int tx;
    int rx;
    logic [3:0] v;
    tx = 0; rx = 0;
    for (int c = 0; c < 40 && rx < 10; c++) begin
      @(negedge clk);
      out_ready = !(c >= 3 && c <= 6);
      if (tx < 10) begin
        v = 4'(tx + 1);
        in_valid = 1'b1; mode = 3'd1;
        for (int ch = 0; ch < 4; ch++) in_data[ch*2 +: 2] = v[ch] ? 2'b10 : 2'b00;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c >= 3 && c <= 6) begin
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL t3_stall_in_ready c=%0d got %b exp 0", c, in_ready); end
      end
      if (out_valid && out_ready) begin
        tests++; if (out_data !== 4'(rx + 1)) begin fails++; $display("FAIL t3_order beat=%0d got %0d exp %0d", rx, out_data, rx + 1); end
        rx++;
      end
      if (in_valid && in_ready) tx++;
    end
    tests++; if (rx !== 10) begin fails++; $display("FAIL t3_beats_out got %0d exp 10", rx); end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1; #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL t3_no_dup got %b exp 0", out_valid); end
    tests++; if (hit_cnt !== 8'd20) begin fails++; $display("FAIL t3_hit_cnt got %0d exp 20", hit_cnt); end
  endtask

  // Reserved mode yields zero result and sets mode_err; cnt_clr clears both counters
  task automatic test_mode_err();
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hFF; mode = 3'd6;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk); #1;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL t4_out_valid got %b exp 1", out_valid); end
    tests++; if (out_data !== 4'd0) begin fails++; $display("FAIL t4_out_data got %b exp 0000", out_data); end
    tests++; if (mode_err !== 1'b1) begin fails++; $display("FAIL t4_mode_err got %b exp 1", mode_err); end
    @(negedge clk); #1;
    tests++; if (hit_cnt !== 8'd20) begin fails++; $display("FAIL t4_hit_unchanged got %0d exp 20", hit_cnt); end
    tests++; if (hit_cnt2 !== 2'd3) begin fails++; $display("FAIL t4_hit_sat got %0d exp 3", hit_cnt2); end
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0; #1;
    tests++; if (mode_err !== 1'b0) begin fails++; $display("FAIL t4_clr_mode_err got %b exp 0", mode_err); end
    tests++; if (hit_cnt !== 8'd0) begin fails++; $display("FAIL t4_clr_hit got %0d exp 0", hit_cnt); end
    tests++; if (hit_cnt2 !== 2'd0) begin fails++; $display("FAIL t4_clr_hit2 got %0d exp 0", hit_cnt2); end
  endtask

  // Saturation on the CNT_W=2 instance, then clear racing a 6th handshake
  task automatic test_saturate();
    logic [1:0] exp2 [5];
    exp2 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'h01; mode = 3'd1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk); #1;
      tests++; if (out_data2 !== 4'b0001) begin fails++; $display("FAIL t5_out_data i=%0d got %b exp 0001", i, out_data2); end
      if (i == 5) cnt_clr = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0; #1;
      if (i < 5) begin
        tests++; if (hit_cnt2 !== exp2[i]) begin fails++; $display("FAIL t5_hit_sat i=%0d got %0d exp %0d", i, hit_cnt2, exp2[i]); end
        tests++; if (hit_cnt !== 8'(i + 1)) begin fails++; $display("FAIL t5_hit i=%0d got %0d exp %0d", i, hit_cnt, i + 1); end
      end else begin
        tests++; if (hit_cnt2 !== 2'd0) begin fails++; $display("FAIL t5_clr_wins2 got %0d exp 0", hit_cnt2); end
        tests++; if (hit_cnt !== 8'd0) begin fails++; $display("FAIL t5_clr_wins got %0d exp 0", hit_cnt); end
      end
    end
  endtask

  // Asynchronous reset with both stages full discards everything
  task automatic test_reset_midflight();
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h01; mode = 3'd1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    tests++; if (hit_cnt !== 8'd1) begin fails++; $display("FAIL t6_pre_hit got %0d exp 1", hit_cnt); end
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h03; mode = 3'd1;
    @(negedge clk);
    in_data = 8'h0C;
    @(negedge clk);
    in_valid = 1'b0; #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL t6_full_in_ready got %b exp 0", in_ready); end
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL t6_full_out_valid got %b exp 1", out_valid); end
    aresetn = 1'b0; #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL t6_rst_out_valid got %b exp 0", out_valid); end
    tests++; if (out_data !== 4'd0) begin fails++; $display("FAIL t6_rst_out_data got %b exp 0000", out_data); end
    tests++; if (hit_cnt !== 8'd0) begin fails++; $display("FAIL t6_rst_hit got %0d exp 0", hit_cnt); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL t6_rst_in_ready got %b exp 0", in_ready); end
    @(negedge clk);
    aresetn = 1'b1; out_ready = 1'b1; #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL t6_release_in_ready got %b exp 1", in_ready); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL t6_ghost_out c=%0d got %b exp 0", c, out_valid); end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_nor_lane0();
    test_modes();
    test_back_to_back();
    test_mode_err();
    test_saturate();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
